// File: rtl/reg_bank_arbiter.sv
// Config register bank with a two-port arbiter (SPI on port 0, I2C on port 1) and read-only access to the status bank.
// Each access runs IDLE -> ACCESS -> ACK. Under the shared policy, the two ports take turns.
module reg_bank_arbiter #(
  parameter int NUM_CFG   = 8,
  parameter int REG_WIDTH = 8,
  parameter int ADDR_W    = $clog2(NUM_CFG) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   sel,
  input  logic                         p0_req,
  input  logic                         p0_we,
  input  logic [ADDR_W-1:0]            p0_addr,
  input  logic [REG_WIDTH-1:0]         p0_wdata,
  output logic                         p0_ack,
  output logic [REG_WIDTH-1:0]         p0_rdata,
  input  logic                         p1_req,
  input  logic                         p1_we,
  input  logic [ADDR_W-1:0]            p1_addr,
  input  logic [REG_WIDTH-1:0]         p1_wdata,
  output logic                         p1_ack,
  output logic [REG_WIDTH-1:0]         p1_rdata,
  output logic [NUM_CFG*REG_WIDTH-1:0] config_regs,
  input  logic [NUM_CFG*REG_WIDTH-1:0] status_regs,
  output logic                         busy,
  output logic                         owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                 state, next_state;
  logic                   owner_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [REG_WIDTH-1:0]   wdata_q;
  logic                   p0_elig, p1_elig, grant_valid, grant_port;
  logic                   is_status;
  logic [REG_WIDTH-1:0]   rd_val;

  assign p0_elig     = p0_req && ((sel == 2'b00) || sel[1]);
  assign p1_elig     = p1_req && ((sel == 2'b01) || sel[1]);
  assign grant_valid = p0_elig || p1_elig;
  // When both ports request, the port that did not win last time gets the grant.
  assign grant_port  = (p0_elig && p1_elig) ? ~owner_q : p1_elig;
  assign is_status   = addr_q[ADDR_W-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_valid) next_state = ACCESS;
      ACCESS:  next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    p0_ack = (state == ACK) && !owner_q;
    p1_ack = (state == ACK) &&  owner_q;
  end

  assign owner = owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && grant_valid) begin
      owner_q <= grant_port;
      we_q    <= grant_port ? p1_we    : p0_we;
      addr_q  <= grant_port ? p1_addr  : p0_addr;
      wdata_q <= grant_port ? p1_wdata : p0_wdata;
    end
  end

  // Register indices that match no register fall through with rd_val = 0.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (addr_q[ADDR_W-2:0] == (ADDR_W-1)'(i))
        rd_val = is_status ? status_regs[i*REG_WIDTH +: REG_WIDTH]
                           : config_regs[i*REG_WIDTH +: REG_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      config_regs <= '0;
    end else if (state == ACCESS && we_q && !is_status) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (addr_q[ADDR_W-2:0] == (ADDR_W-1)'(i))
          config_regs[i*REG_WIDTH +: REG_WIDTH] <= wdata_q;
      end
    end
  end

  // rdata changes only when an access completes; on a write it returns 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else if (state == ACCESS) begin
      if (owner_q) p1_rdata <= we_q ? '0 : rd_val;
      else         p0_rdata <= we_q ? '0 : rd_val;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed test of reg_bank_arbiter: a default instance plus a NUM_CFG=4 instance driven by the same requests.
// The second instance covers register indices that lie past the end of the bank.
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [3:0]  p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack, busy, owner;
  logic [7:0]  p0_rdata, p1_rdata;
  logic [63:0] config_regs;
  logic [63:0] status_regs;
  logic        p0_ack2, p1_ack2, busy2, owner2;
  logic [7:0]  p0_rdata2, p1_rdata2;
  logic [31:0] config_regs2;
  logic [31:0] status_regs2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign status_regs2 = status_regs[31:0];

  reg_bank_arbiter dut (
    .clk(clk), .rst(rst), .sel(sel),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .config_regs(config_regs), .status_regs(status_regs),
    .busy(busy), .owner(owner)
  );

  reg_bank_arbiter #(.NUM_CFG(4), .REG_WIDTH(8), .ADDR_W(4)) dut_small (
    .clk(clk), .rst(rst), .sel(sel),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack2), .p0_rdata(p0_rdata2),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack2), .p1_rdata(p1_rdata2),
    .config_regs(config_regs2), .status_regs(status_regs2),
    .busy(busy2), .owner(owner2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic port, input logic req, input logic we,
                               input logic [3:0] addr, input logic [7:0] wdata);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    logic exp_owner;
    rst = 1'b1;
    sel = 2'b00;
    status_regs = 64'h77_66_55_44_33_22_10_CA;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);

    tick(); tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 1);
    rst = 1'b0;
    tick();
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_acks", {p0_ack, p1_ack}, 0);
    checkOutput("idle_rdata", {p0_rdata, p1_rdata}, 0);
    checkOutput("idle_cfg", config_regs, 0);

    // sel=00: p0 writes 0xA5 to reg 0 while p1, which is not eligible, keeps requesting.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 8'hA5);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h1, 8'h00);
    tick();
    checkOutput("wr0_access_busy", busy, 1);
    checkOutput("wr0_access_owner", owner, 0);
    checkOutput("wr0_access_ack", p0_ack, 0);
    tick();
    checkOutput("wr0_ack", {p0_ack, p1_ack}, 2'b10);
    checkOutput("wr0_cfg", config_regs[7:0], 8'hA5);
    p0_req = 1'b0;
    tick();
    checkOutput("wr0_back_idle", busy, 0);
    tick();
    checkOutput("p1_stalled_busy", busy, 0);
    checkOutput("p1_stalled_ack", p1_ack, 0);

    // sel=01: only p1 is granted. sel moves to 00 during ACCESS; p0 is granted next.
    sel = 2'b01;
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h2, 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 8'h00);
    tick();
    checkOutput("sel01_owner", owner, 1);
    sel = 2'b00;
    tick();
    checkOutput("sel01_ack", {p0_ack, p1_ack}, 2'b01);
    checkOutput("sel01_cfg", config_regs, 64'h0000_0000_003C_00A5);
    p1_req = 1'b0;
    tick();
    checkOutput("sel00_idle", busy, 0);
    tick();
    checkOutput("sel00_owner", owner, 0);
    tick();
    checkOutput("sel00_ack", {p0_ack, p1_ack}, 2'b10);
    checkOutput("sel00_rdata", p0_rdata, 8'hA5);
    p0_req = 1'b0;
    tick();

    // sel=10: both ports keep requesting. Last grant was p0, so turns go p1,p0,p1,p0.
    sel = 2'b10;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h8, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h9, 8'h00);
    for (int i = 0; i < 4; i++) begin
      exp_owner = (i % 2 == 0);
      tick();
      checkOutput("rr_owner", owner, exp_owner);
      tick();
      checkOutput("rr_ack", {p0_ack, p1_ack}, exp_owner ? 2'b01 : 2'b10);
      if (exp_owner) checkOutput("rr_p1_rdata", p1_rdata, 8'h10);
      else           checkOutput("rr_p0_rdata", p0_rdata, 8'hCA);
      if (i == 3) begin
        p0_req = 1'b0;
        p1_req = 1'b0;
      end
      tick();
      checkOutput("rr_idle", busy, 0);
    end

    // p1 writes to the status bank. The write is dropped and the ack returns rdata 0.
    sel = 2'b01;
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h8, 8'h33);
    tick(); tick();
    checkOutput("stwr_ack", p1_ack, 1);
    checkOutput("stwr_rdata", p1_rdata, 8'h00);
    checkOutput("stwr_cfg", config_regs, 64'h0000_0000_003C_00A5);
    checkOutput("stwr_ack_small", p1_ack2, 1);
    checkOutput("stwr_rdata_small", p1_rdata2, 8'h00);
    checkOutput("stwr_cfg_small", config_regs2, 32'h003C_00A5);
    p1_req = 1'b0;
    tick();

    // Read addr 15: status reg 7 on the full bank, an index past the end on the NUM_CFG=4 bank.
    sel = 2'b00;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 8'h00);
    tick();
    checkOutput("oor_owner_small", owner2, 0);
    tick();
    checkOutput("oor_rdata", p0_rdata, 8'h77);
    checkOutput("oor_ack_small", p0_ack2, 1);
    checkOutput("oor_rdata_small", p0_rdata2, 8'h00);
    p0_req = 1'b0;
    tick();
    checkOutput("oor_idle_small", busy2, 0);

    // Write 0x5A to reg 3. A second write to reg 3 is cut off by reset during ACCESS.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h3, 8'h5A);
    tick(); tick();
    checkOutput("wr3_ack", p0_ack, 1);
    checkOutput("wr3_cfg", config_regs, 64'h0000_0000_5A3C_00A5);
    p0_req = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h3, 8'h99);
    tick();
    checkOutput("rstmid_access", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0_req = 1'b0;
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_cfg", config_regs, 0);
    checkOutput("rstmid_owner", owner, 1);
    tick();
    checkOutput("rstmid_no_ack", {p0_ack, p1_ack}, 0);
    checkOutput("rstmid_cfg_after", config_regs, 0);
    checkOutput("rstmid_cfg_small", config_regs2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
